xs3_serial_adder_ctrl: RTL and testbench

//  Multi-digit BCD adder that performs one Excess-3 digit addition per clock, least significant digit first.

---
 rtl/xs3_pkg.sv | 15 +
 rtl/xs3_digit_add.sv | 32 +++
 rtl/xs3_serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_xs3_serial_adder_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared types and constants for the Excess-3 serial BCD adder.
// Holds the controller state encoding and the digit-arithmetic constants.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } xs3_state_t;

  localparam logic [3:0] XS3_BIAS = 4'd3;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/xs3_digit_add.sv
// One-digit Excess-3 adder slice, purely combinational.
// Latency: none. Backpressure: none, the controller sequences it.
module xs3_digit_add
  import xs3_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] bcd,
  output logic [3:0] xs3,
  output logic       cout,
  output logic       bad
);

  logic [4:0] s;

  always_comb begin
    s    = {1'b0, a} + {1'b0, XS3_BIAS} + {1'b0, b} + {1'b0, XS3_BIAS} + {4'd0, cin};
    cout = s[4];
    // A carry out of the biased sum leaves the low nibble as plain BCD;
    // otherwise the nibble still carries both biases and needs the correction.
    if (s[4]) begin
      bcd = s[3:0];
      xs3 = s[3:0] + XS3_BIAS;
    end else begin
      bcd = s[3:0] - BCD_CORR;
      xs3 = s[3:0] - XS3_BIAS;
    end
    bad = (a > BCD_MAX) || (b > BCD_MAX);
  end

endmodule

// File: rtl/xs3_serial_adder_ctrl.sv
// Serial multi-digit BCD adder, one Excess-3 digit per clock, LSD first.
// Latency: DIGITS+1 cycles to out_valid; result held until out_ready, no accept while busy.
module xs3_serial_adder_ctrl
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic [4*DIGITS-1:0]   sum_xs3,
  output logic                  carry_out,
  output logic                  bad_digit
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  xs3_state_t          state_q, state_d;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] a_q, b_q;
  logic                carry_q;
  logic                last_digit;

  logic [3:0] dig_a, dig_b, dig_bcd, dig_xs3;
  logic       dig_cout, dig_bad;

  assign last_digit = (idx == IW'(DIGITS - 1));
  assign dig_a      = a_q[{idx, 2'b00} +: 4];
  assign dig_b      = b_q[{idx, 2'b00} +: 4];

  xs3_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .bcd  (dig_bcd),
    .xs3  (dig_xs3),
    .cout (dig_cout),
    .bad  (dig_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum_bcd   <= '0;
      sum_xs3   <= '0;
      carry_out <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a_bcd;
            b_q       <= b_bcd;
            carry_q   <= carry_in;
            bad_digit <= 1'b0;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_bcd[{idx, 2'b00} +: 4] <= dig_bcd;
          sum_xs3[{idx, 2'b00} +: 4] <= dig_xs3;
          carry_q   <= dig_cout;
          bad_digit <= bad_digit | dig_bad;
          if (last_digit) carry_out <= dig_cout;
          else            idx       <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_serial_adder_ctrl.sv
// Randomised scoreboard bench for the serial Excess-3 BCD adder (DIGITS=4).
module tb_xs3_serial_adder_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_bcd = '0;
  logic [W-1:0] b_bcd = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_bcd;
  logic [W-1:0] sum_xs3;
  logic         carry_out;
  logic         bad_digit;

  xs3_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_bcd   (sum_bcd),
    .sum_xs3   (sum_xs3),
    .carry_out (carry_out),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bcd;
    logic [W-1:0] xs3;
    logic         co;
    logic         bad;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: treat operands as decimal integers, add, then re-encode.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    int av = 0, bv = 0, p = 1, s;
    e.bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      int da = int'(a[4*i +: 4]);
      int db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) e.bad = 1'b1;
      av += da * p;
      bv += db * p;
      p  *= 10;
    end
    s    = av + bv + int'(cin);
    e.co = (s >= p);
    s    = s % p;
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'(s % 10);
      e.xs3[4*i +: 4] = 4'(s % 10 + 3);
      s = s / 10;
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor: pop on each rising out_valid, then demand stability while held.
  logic prev_v = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          cur = q.pop_front();
          check("latency", 32'(cyc - cur.acc), 32'(D + 1));
          check("bad_digit", 32'(bad_digit), 32'(cur.bad));
          if (!cur.bad) begin
            check("sum_bcd", 32'(sum_bcd), 32'(cur.bcd));
            check("sum_xs3", 32'(sum_xs3), 32'(cur.xs3));
            check("carry_out", 32'(carry_out), 32'(cur.co));
          end
        end
      end else if (out_valid && prev_v && !cur.bad) begin
        check("hold_stable", {sum_bcd, sum_xs3} ^ {cur.bcd, cur.xs3}, 32'd0);
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a_bcd    = a;
    b_bcd    = b;
    carry_in = cin;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
    else if (push) begin
      e     = model(a, b, cin);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_bcd    = W'($urandom);
    b_bcd    = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int dly);
    out_ready = (dly == 0);
    send(a, b, cin, 1'b1);
    wait_valid();
    repeat (dly) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("release", 32'(out_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] rnd_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++)
      v[4*i +: 4] = (allow_bad && $urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 10))
                                                             : 4'($urandom_range(9, 0));
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset with noisy inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      a_bcd    = W'($urandom);
      b_bcd    = W'($urandom);
      carry_in = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_sums", {sum_bcd, sum_xs3}, 32'd0);
      check("rst_flags", {30'd0, carry_out, bad_digit}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h9999, 16'h9999, 1'b1, 2);

    // Backpressure in DONE with in_valid pulses
    e = model(16'h4321, 16'h1111, 1'b0);
    out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b0, 1'b1);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_bcd    = rnd_bcd(0);
      b_bcd    = rnd_bcd(0);
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", {sum_bcd, sum_xs3}, {e.bcd, e.xs3});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);

    // Invalid digit, then reset in the middle of the next operation
    run_op(16'h00A0, 16'h0000, 1'b0, 0);
    send(16'h0042, 16'h0013, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_quiet", {30'd0, out_valid, in_ready}, 32'd1);
    end
    run_op(16'h0005, 16'h0005, 1'b0, 0);

    // Random operations, occasionally with invalid digits and backpressure
    for (int n = 0; n < 60; n++)
      run_op(rnd_bcd(1), rnd_bcd(1), 1'($urandom), int'($urandom_range(3, 0)));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
